// File: rtl/fetch_buffer_if.sv
// Fetch-buffer handshake bundle: redirect, instruction-memory request/response and decode ports.
// master = fetch_buffer side, slave = surrounding pipeline/memory side.
interface fetch_buffer_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_insn;
  logic        d_ready;

  modport master (
    input  redirect, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, d_ready,
    output mem_req_valid, mem_req_addr, d_valid, d_pc, d_insn
  );

  modport slave (
    output redirect, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, d_ready,
    input  mem_req_valid, mem_req_addr, d_valid, d_pc, d_insn
  );
endinterface

// File: rtl/fetch_buffer.sv
// Credit-based instruction fetch buffer: PC tag FIFO for in-flight reads, {pc, insn} FIFO to decode.
// Optional macro FETCH_BUFFER_BYPASS_EN presents a response combinationally when the FIFO is empty.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic           clock,
  input  logic           reset,
  fetch_buffer_if.master bus
);

  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_L = DEPTH[CNT_W:0];

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      fifo_pc_q   [DEPTH];
  logic [31:0]      fifo_pc_d   [DEPTH];
  logic [31:0]      fifo_insn_q [DEPTH];
  logic [31:0]      fifo_insn_d [DEPTH];
  logic [31:0]      tag_q       [DEPTH];
  logic [31:0]      tag_d       [DEPTH];
  logic [CNT_W-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   credit_sum;
  logic             fifo_empty;
  logic             req_valid, req_fire;
  logic             resp_ok, resp_live, resp_stale;
  logic             bypass_hit, bypass_take;
  logic             push, pop;
  logic [31:0]      tag_head;

  always_comb begin
    occupancy  = fifo_wr_q - fifo_rd_q;
    fifo_empty = (occupancy == '0);
    credit_sum = {1'b0, outstanding_q} + {1'b0, occupancy};
    req_valid  = !reset && !bus.redirect && (credit_sum < DEPTH_L);
    req_fire   = req_valid && bus.mem_req_ready;
    // A response with nothing outstanding is spurious and never touches state.
    resp_ok    = !reset && bus.mem_resp_valid && (outstanding_q != '0);
    resp_live  = resp_ok && (discard_q == '0);
    resp_stale = resp_ok && (discard_q != '0);
    tag_head   = tag_q[tag_rd_q];
`ifdef FETCH_BUFFER_BYPASS_EN
    bypass_hit = resp_live && fifo_empty && !bus.redirect;
`else
    bypass_hit = 1'b0;
`endif
    bypass_take = bypass_hit && bus.d_ready;
    pop         = !reset && !bus.redirect && !fifo_empty && bus.d_ready;
    push        = resp_live && !bypass_take;
  end

  always_comb begin
    bus.mem_req_valid = req_valid;
    bus.mem_req_addr  = fetch_pc_q & 32'hFFFF_FFFC;
    bus.d_valid       = !reset && (!fifo_empty || bypass_hit);
    bus.d_pc          = '0;
    bus.d_insn        = '0;
    if (!reset && !fifo_empty) begin
      bus.d_pc   = fifo_pc_q[fifo_rd_q[PTR_W-1:0]];
      bus.d_insn = fifo_insn_q[fifo_rd_q[PTR_W-1:0]];
    end else if (bypass_hit) begin
      bus.d_pc   = tag_head;
      bus.d_insn = bus.mem_resp_data;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_insn_d   = fifo_insn_q;
    tag_d         = tag_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_wr_d     = fifo_wr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (bus.redirect) begin
      // Everything still in flight becomes stale; a response landing this cycle is already gone.
      fetch_pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
      fifo_rd_d     = '0;
      fifo_wr_d     = '0;
      tag_rd_d      = '0;
      tag_wr_d      = '0;
      outstanding_d = outstanding_q - {{(CNT_W-1){1'b0}}, resp_ok};
      discard_d     = outstanding_q - {{(CNT_W-1){1'b0}}, resp_ok};
    end else begin
      if (req_fire) begin
        tag_d[tag_wr_q] = fetch_pc_q;
        tag_wr_d        = tag_wr_q + PTR_W'(1);
        fetch_pc_d      = fetch_pc_q + 32'd4;
      end
      if (resp_live) begin
        tag_rd_d = tag_rd_q + PTR_W'(1);
      end
      if (push) begin
        fifo_pc_d[fifo_wr_q[PTR_W-1:0]]   = tag_head;
        fifo_insn_d[fifo_wr_q[PTR_W-1:0]] = bus.mem_resp_data;
        fifo_wr_d                         = fifo_wr_q + CNT_W'(1);
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + CNT_W'(1);
      end
      if (resp_stale) begin
        discard_d = discard_q - CNT_W'(1);
      end
      outstanding_d = outstanding_q + {{(CNT_W-1){1'b0}}, req_fire}
                                    - {{(CNT_W-1){1'b0}}, resp_ok};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Storage arrays need no reset: pointers alone define validity.
  always_ff @(posedge clock) begin
    fifo_pc_q   <= fifo_pc_d;
    fifo_insn_q <= fifo_insn_d;
    tag_q       <= tag_d;
  end

endmodule
